mod_mul_seq: RTL and testbench

//  Sequential modular multiplier: result = (a_in * b_in) mod modular, one multiplier bit per cycle.

---
 rtl/mod_mul_seq.sv | 109 ++++++++++
 tb/tb_mod_mul_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: result = (a_in * b_in) mod modular, one multiplier
// bit per cycle (MSB first, double-and-add), valid/ready handshake on both sides.
module mod_mul_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] modular,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     mod_q, mod_d;
  logic [W:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;

  // One double-and-add step; W+1-bit arithmetic never overflows while acc < q.
  logic [W:0] dbl, dbl_red, sum, sum_red, mod_ext;

  always_comb begin
    mod_ext = {1'b0, mod_q};
    dbl     = acc_q << 1;
    dbl_red = (dbl >= mod_ext) ? dbl - mod_ext : dbl;
    sum     = b_q[cnt_q] ? dbl_red + {1'b0, a_q} : dbl_red;
    sum_red = (sum >= mod_ext) ? sum - mod_ext : sum;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          // An out-of-range multiplicand is replaced by 0 so acc stays below q.
          a_d     = (a_in < modular) ? a_in : '0;
          b_d     = b_in;
          mod_d   = modular;
          acc_d   = '0;
          cnt_d   = CNT_LAST;
        end
      end
      ST_RUN: begin
        acc_d = sum_red;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = sum_red[W-1:0];
          cnt_d    = CNT_LAST;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so all
  // registers update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= CNT_LAST;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed self-checking bench for mod_mul_seq: hand-computed vectors, handshake,
// stall, reset-abort, plus a short random sweep against a 64-bit reference.
module tb_mod_mul_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in, modular;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int tests_run    = 0;
  int tests_failed = 0;

  mod_mul_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .modular   (modular),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; pulses in_valid with junk while busy and stalls out_ready
  // for `hold` cycles in DONE.
  task automatic do_op(input string tag, input logic [W-1:0] q, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp,
                       input int hold, input bit chk_lat);
    int  n;
    bit  busy_bad;
    bit  stall_bad;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check({tag, "_idle_ready"}, in_ready, 1);
    in_valid = 1'b1; a_in = a; b_in = b; modular = q; out_ready = 1'b0;
    tick();
    a_in = ~a; b_in = ~b; modular = q ^ 32'h5a5a_0f0f;
    n = 0; busy_bad = 1'b0;
    while (!out_valid && n < 100) begin
      in_valid = n[0];
      tick();
      n++;
      if (in_ready) busy_bad = 1'b1;
    end
    check({tag, "_busy_not_ready"}, busy_bad, 0);
    if (chk_lat) check({tag, "_latency"}, n, W);
    check({tag, "_result"}, result, exp);
    stall_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick();
      if (!out_valid || result !== exp || in_ready) stall_bad = 1'b1;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "_stall_stable"}, stall_bad, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_handoff_valid"}, out_valid, 0);
    check({tag, "_handoff_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] q, a, b;
    logic [63:0]  prod;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; modular = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    tick();

    do_op("t1_small", 32'd12289, 32'd3, 32'd5, 32'd15, 0, 1'b1);
    do_op("t2_minus1_sq", 32'd12289, 32'd12288, 32'd12288, 32'd1, 0, 1'b1);
    do_op("t2_q7681", 32'd7681, 32'd7680, 32'd2, 32'd7679, 0, 1'b1);
    do_op("t3_a_zero", 32'd12289, 32'd0, 32'd12288, 32'd0, 0, 1'b0);
    do_op("t3_b_zero", 32'd12289, 32'd9999, 32'd0, 32'd0, 0, 1'b0);
    do_op("t3_b_one", 32'd12289, 32'd9999, 32'd1, 32'd9999, 0, 1'b0);
    do_op("t4_stall", 32'd12289, 32'd100, 32'd200, 32'd7711, 5, 1'b1);
    do_op("max_q", 32'hffff_ffff, 32'hffff_fffe, 32'hffff_fffe, 32'd1, 1, 1'b0);
    do_op("q_two", 32'd2, 32'd1, 32'd1, 32'd1, 0, 1'b0);
    do_op("big_pow2", 32'hffff_fffb, 32'h8000_0000, 32'd2, 32'd5, 0, 1'b0);

    // Reset lands on the 10th RUN edge.
    in_valid = 1'b1; a_in = 32'd1234; b_in = 32'd4321; modular = 32'd12289;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("t5_abort_valid", out_valid, 0);
    check("t5_abort_ready", in_ready, 1);
    check("t5_abort_result", result, 0);
    rst = 1'b0;
    tick();
    do_op("t5_after_rst", 32'd97, 32'd50, 32'd60, 32'd90, 0, 1'b1);

    for (int k = 0; k < 150; k++) begin
      q = $urandom();
      if (q < 2) q = 32'd2;
      a = $urandom() % q;
      b = $urandom() % q;
      prod = (64'(a) * 64'(b)) % 64'(q);
      do_op("t6_random", q, a, b, prod[W-1:0], $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
